maxmin_frame_writer: RTL and testbench



---
 rtl/maxmin_pkg.sv | 17 +
 rtl/mm_group_fifo.sv | 56 +++++
 rtl/maxmin_frame_writer.sv | 184 ++++++++++++++++++
 tb/tb_maxmin_frame_writer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxmin_pkg.sv
// Shared types and constants for the max/min envelope frame writer.
package maxmin_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned PAIR_W = 16;
  localparam int unsigned SAMP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One decimated group: element [i] is lane i as {max, min}.
  typedef logic [LANES-1:0][PAIR_W-1:0] group_t;

endpackage

// File: rtl/mm_group_fifo.sv
// Show-ahead group buffer. A push while full is accepted when a pop
// happens in the same cycle; flush empties the buffer immediately.
module mm_group_fifo
  import maxmin_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_push,
  input  logic   i_pop,
  input  logic   i_flush,
  input  group_t i_din,
  output group_t o_dout,
  output logic   o_full,
  output logic   o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  group_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/maxmin_frame_writer.sv
// Buffers max/min envelope groups and serializes them into the waveform
// RAM one {max,min} pair per clock, counting pairs against an armed length.
module maxmin_frame_writer
  import maxmin_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned GRP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              enin,
  input  logic [SAMP_W-1:0] s20max,
  input  logic [SAMP_W-1:0] s20min,
  input  logic [SAMP_W-1:0] s21max,
  input  logic [SAMP_W-1:0] s21min,
  input  logic [SAMP_W-1:0] s22max,
  input  logic [SAMP_W-1:0] s22min,
  input  logic [SAMP_W-1:0] s23max,
  input  logic [SAMP_W-1:0] s23min,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PAIR_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_wcnt;
  group_t            r_grp;
  logic [1:0]        r_lane;
  logic              r_active;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [PAIR_W-1:0] r_ram_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;

  group_t            w_grp_in;
  group_t            w_grp_new;
  group_t            w_fifo_dout;
  logic [PAIR_W-1:0] w_pair;
  logic [ADDR_W:0]   w_len_clamp;
  logic              w_run;
  logic              w_in_valid;
  logic              w_wr;
  logic              w_load;
  logic              w_pop;
  logic              w_bypass;
  logic              w_push;
  logic              w_drop;
  logic              w_last;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  state_t            w_state_nxt;

  assign w_grp_in    = {s23max, s23min, s22max, s22min, s21max, s21min, s20max, s20min};
  assign w_len_clamp = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
  assign w_run       = (r_state == RUN) && !arm;
  assign w_in_valid  = w_run && enin;
  assign w_push      = w_in_valid && !w_bypass && (!w_fifo_full || w_pop);
  assign w_drop      = w_in_valid && !w_bypass && w_fifo_full && !w_pop;
  assign w_last      = w_wr && ((r_wcnt + 1'b1) == r_len);

  mm_group_fifo #(
    .DEPTH (GRP_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (arm || w_last),
    .i_din   (w_grp_in),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Pick this cycle's write source: remaining lanes, then buffered group,
  // then the incoming group directly so an idle path writes lane 0 at t+1.
  always_comb begin
    w_wr      = 1'b0;
    w_load    = 1'b0;
    w_pop     = 1'b0;
    w_bypass  = 1'b0;
    w_grp_new = w_fifo_dout;
    if (w_run) begin
      if (r_active) begin
        w_wr = 1'b1;
      end else if (!w_fifo_empty) begin
        w_wr   = 1'b1;
        w_pop  = 1'b1;
        w_load = 1'b1;
      end else if (enin) begin
        w_wr      = 1'b1;
        w_load    = 1'b1;
        w_bypass  = 1'b1;
        w_grp_new = w_grp_in;
      end
    end
    w_pair = w_load ? w_grp_new[0] : r_grp[r_lane];
  end

  // Next-state decode; arm overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (arm) w_state_nxt = (w_len_clamp == '0) ? DONE : RUN;
    else if (w_last) w_state_nxt = DONE;
  end

  // State, status flags and latched frame length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      // done trails entry into DONE by a cycle, except a zero-length arm
      r_done  <= arm ? (w_state_nxt == DONE) : (r_state == DONE);
      if (arm) begin
        r_len <= w_len_clamp;
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Serializer: holds the group in flight and counts written pairs.
  always_ff @(posedge clk) begin
    if (!rst_n || arm) begin
      r_grp    <= '0;
      r_lane   <= '0;
      r_active <= 1'b0;
      r_wcnt   <= '0;
    end else begin
      if (w_wr) r_wcnt <= r_wcnt + 1'b1;
      if (w_load) begin
        r_grp    <= w_grp_new;
        r_lane   <= 2'd1;
        r_active <= 1'b1;
      end else if (w_wr) begin
        r_lane <= r_lane + 1'b1;
        if (r_lane == 2'd3) r_active <= 1'b0;
      end
      if (w_last) r_active <= 1'b0;
    end
  end

  // Registered RAM write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_we <= w_wr;
      if (arm) begin
        r_ram_addr <= '0;
      end else if (w_wr) begin
        r_ram_addr  <= r_wcnt[ADDR_W-1:0];
        r_ram_wdata <= w_pair;
      end
    end
  end

  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_maxmin_frame_writer.sv
// Self-checking bench for maxmin_frame_writer with a queue-based reference model.
module tb_maxmin_frame_writer;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 2;
  localparam int          MAXLEN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          enin = 1'b0;
  logic [AW:0]   frame_len = '0;
  logic [63:0]   grp_in = '0;
  logic [7:0]    s20max, s20min, s21max, s21min, s22max, s22min, s23max, s23min;
  logic          ram_we, busy, done, ovf;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;

  assign s20min = grp_in[7:0];   assign s20max = grp_in[15:8];
  assign s21min = grp_in[23:16]; assign s21max = grp_in[31:24];
  assign s22min = grp_in[39:32]; assign s22max = grp_in[47:40];
  assign s23min = grp_in[55:48]; assign s23max = grp_in[63:56];

  always #5 clk = ~clk;

  maxmin_frame_writer #(
    .ADDR_W    (AW),
    .GRP_DEPTH (DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .frame_len(frame_len), .enin(enin),
    .s20max(s20max), .s20min(s20min), .s21max(s21max), .s21min(s21min),
    .s22max(s22max), .s22min(s22min), .s23max(s23max), .s23min(s23min),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .ovf(ovf)
  );

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  // Reference model: 0=idle 1=run 2=done; lanes still to write and buffered groups.
  int          m_state = 0;
  int          m_len = 0;
  int          m_cnt = 0;
  logic [15:0] m_lanes[$];
  logic [63:0] m_buf[$];
  logic        m_ovf = 0, m_done = 0, m_busy = 0;

  // Advance model and DUT by one clock; log expected and observed writes.
  task automatic clk_cycle();
    logic [63:0] g;
    logic [15:0] pd;
    bit          wr, popped, used, nd;
    int          occ, ns, len;
    wr_t         e, o;
    wr = 0; popped = 0; used = 0; nd = 0; pd = '0; ns = m_state;
    occ = m_buf.size();
    if (!rst_n) begin
      m_len = 0; m_cnt = 0; m_lanes.delete(); m_buf.delete(); m_ovf = 0; ns = 0;
    end else if (arm) begin
      len = (int'(frame_len) > MAXLEN) ? MAXLEN : int'(frame_len);
      m_len = len; m_cnt = 0; m_lanes.delete(); m_buf.delete(); m_ovf = 0;
      nd = (len == 0);
      ns = (len == 0) ? 2 : 1;
    end else begin
      nd = (m_state == 2);
      if (m_state == 1) begin
        if (m_lanes.size() > 0) begin
          wr = 1; pd = m_lanes.pop_front();
        end else if (m_buf.size() > 0 || enin) begin
          if (m_buf.size() > 0) begin g = m_buf.pop_front(); popped = 1; end
          else begin g = grp_in; used = 1; end
          wr = 1; pd = g[15:0];
          m_lanes.push_back(g[31:16]); m_lanes.push_back(g[47:32]); m_lanes.push_back(g[63:48]);
        end
        if (enin && !used) begin
          if (occ < DEPTH || popped) m_buf.push_back(grp_in);
          else m_ovf = 1;
        end
        if (wr) begin
          e.cyc = 32'(cyc + 1); e.addr = AW'(m_cnt); e.data = pd;
          exp_q.push_back(e);
          m_cnt++;
          if (m_cnt == m_len) begin ns = 2; m_lanes.delete(); m_buf.delete(); end
        end
      end
    end
    m_state = ns; m_done = nd; m_busy = (ns == 1);
    @(posedge clk);
    #1;
    cyc++;
    if (ram_we === 1'b1) begin
      o.cyc = 32'(cyc); o.addr = ram_addr; o.data = ram_wdata;
      obs_q.push_back(o);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) clk_cycle();
  endtask

  task automatic pulse_arm(input int len);
    arm = 1'b1; frame_len = (AW+1)'(len);
    clk_cycle();
    arm = 1'b0;
  endtask

  task automatic send_group(input logic [63:0] g);
    grp_in = g; enin = 1'b1;
    clk_cycle();
    enin = 1'b0;
  endtask

  task automatic clear_logs();
    exp_q.delete(); obs_q.delete();
  endtask

  function automatic logic [63:0] pat_group(input int k);
    logic [63:0] g;
    for (int j = 0; j < 4; j++) g[16*j +: 16] = 16'(32'h1000 + 32'h0101 * (k + j));
    return g;
  endfunction

  function automatic logic [63:0] rnd_group();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b0; enin = 1'b0;
    idle(2);
    rst_n = 1'b1;
    checks += 6;
    if (ram_we !== 1'b0)    begin failures++; $display("FAIL reset_we: got %b want 0", ram_we); end
    if (ram_addr !== '0)    begin failures++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
    if (ram_wdata !== '0)   begin failures++; $display("FAIL reset_wdata: got %h want 0", ram_wdata); end
    if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    if (ovf !== 1'b0)       begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_frame8();
    logic [15:0] d;
    clear_logs();
    pulse_arm(8);
    idle(1);
    send_group(pat_group(0));
    idle(9);
    send_group(pat_group(4));
    idle(3);
    checks += 3;
    if (ram_we !== 1'b1 || ram_addr !== AW'(7)) begin failures++; $display("FAIL frame8_last: got we=%b addr=%0d want we=1 addr=7", ram_we, ram_addr); end
    if (done !== 1'b0) begin failures++; $display("FAIL frame8_done_early: got %b want 0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL frame8_busy_end: got %b want 0", busy); end
    idle(1);
    checks += 2;
    if (done !== 1'b1) begin failures++; $display("FAIL frame8_done: got %b want 1", done); end
    if (ram_we !== 1'b0) begin failures++; $display("FAIL frame8_we_after: got %b want 0", ram_we); end
    idle(3);
    checks++;
    if (obs_q.size() != 8) begin failures++; $display("FAIL frame8_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      d = 16'(32'h1000 + 32'h0101 * i);
      checks++;
      if (obs_q[i].addr !== AW'(i) || obs_q[i].data !== d) begin
        failures++; $display("FAIL frame8_pair[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, obs_q[i].addr, obs_q[i].data, i, d);
      end
    end
    checks++;
    if (obs_q !== exp_q) begin failures++; $display("FAIL frame8_timing: got %0d writes (first cyc %0d) want %0d (first cyc %0d)", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].cyc : 0, exp_q.size(), (exp_q.size() > 0) ? exp_q[0].cyc : 0); end
  endtask

  task automatic test_frame6();
    logic [63:0] g1, g2;
    clear_logs();
    g1 = rnd_group(); g2 = rnd_group();
    pulse_arm(6);
    send_group(g1);
    idle(3);
    send_group(g2);
    idle(6);
    checks += 3;
    if (obs_q.size() != 6) begin failures++; $display("FAIL frame6_count: got %0d want 6", obs_q.size()); end
    else if (obs_q[4].data !== g2[15:0] || obs_q[5].data !== g2[31:16] || obs_q[5].addr !== AW'(5)) begin
      failures++; $display("FAIL frame6_tail: got %h/%h addr=%0d want %h/%h addr=5", obs_q[4].data, obs_q[5].data, obs_q[5].addr, g2[15:0], g2[31:16]);
    end
    if (done !== 1'b1) begin failures++; $display("FAIL frame6_done: got %b want 1", done); end
    if (obs_q !== exp_q) begin failures++; $display("FAIL frame6_model: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_overflow();
    logic [63:0] g[5];
    clear_logs();
    pulse_arm(64);
    enin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      g[i] = rnd_group(); grp_in = g[i];
      clk_cycle();
    end
    enin = 1'b0;
    idle(25);
    checks += 4;
    if (ovf !== 1'b1)  begin failures++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    if (busy !== 1'b1) begin failures++; $display("FAIL ovf_busy: got %b want 1", busy); end
    if (obs_q.size() < 12) begin failures++; $display("FAIL ovf_count: got %0d want >=12", obs_q.size()); end
    else begin
      for (int i = 0; i < 12; i++) begin
        if (obs_q[i].data !== g[i/4][16*(i%4) +: 16]) begin
          failures++; $display("FAIL ovf_pair[%0d]: got %h want %h", i, obs_q[i].data, g[i/4][16*(i%4) +: 16]);
          break;
        end
      end
    end
    if (obs_q !== exp_q || ovf !== m_ovf) begin failures++; $display("FAIL ovf_model: got %0d writes ovf=%b want %0d ovf=%b", obs_q.size(), ovf, exp_q.size(), m_ovf); end
  endtask

  task automatic test_zero_len_and_arm_enin();
    logic [63:0] g0, g1;
    clear_logs();
    pulse_arm(0);
    checks += 2;
    if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done: got done=%b busy=%b want 1/0", done, busy); end
    idle(3);
    if (obs_q.size() != 0) begin failures++; $display("FAIL zero_writes: got %0d want 0", obs_q.size()); end
    g0 = rnd_group(); g1 = rnd_group();
    arm = 1'b1; frame_len = 8; enin = 1'b1; grp_in = g0;
    clk_cycle();
    arm = 1'b0; enin = 1'b0;
    checks += 2;
    if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL armen_state: got busy=%b done=%b want 1/0", busy, done); end
    idle(2);
    send_group(g1);
    idle(4);
    if (obs_q.size() != 4 || obs_q[0].addr !== '0 || obs_q[0].data !== g1[15:0]) begin
      failures++; $display("FAIL armen_first: got n=%0d addr=%0d data=%h want n=4 addr=0 data=%h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].addr : '1, (obs_q.size() > 0) ? obs_q[0].data : 16'h0, g1[15:0]);
    end
    checks++;
    if (obs_q !== exp_q) begin failures++; $display("FAIL armen_model: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_done_ignore();
    clear_logs();
    pulse_arm(4);
    enin = 1'b1;
    for (int i = 0; i < 4; i++) begin grp_in = rnd_group(); clk_cycle(); end
    enin = 1'b0;
    idle(2);
    checks += 2;
    if (done !== 1'b1 || ovf !== 1'b1) begin failures++; $display("FAIL dn_flags: got done=%b ovf=%b want 1/1", done, ovf); end
    if (obs_q !== exp_q || obs_q.size() != 4) begin failures++; $display("FAIL dn_burst: got %0d writes want 4", obs_q.size()); end
    clear_logs();
    for (int i = 0; i < 3; i++) begin send_group(rnd_group()); idle(1); end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL dn_ignored: got %0d writes want 0", obs_q.size()); end
    pulse_arm(4);
    checks++;
    if (done !== 1'b0 || ovf !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL dn_rearm: got done=%b ovf=%b busy=%b want 0/0/1", done, ovf, busy); end
    send_group(rnd_group());
    idle(4);
    checks++;
    if (obs_q.size() != 4 || obs_q[0].addr !== '0 || obs_q !== exp_q) begin failures++; $display("FAIL dn_restart: got %0d writes want 4 from addr 0", obs_q.size()); end
  endtask

  task automatic test_clamp();
    clear_logs();
    pulse_arm(100);
    for (int i = 0; i < 17; i++) begin send_group(rnd_group()); idle(3); end
    idle(2);
    checks += 3;
    if (obs_q.size() != MAXLEN || obs_q[MAXLEN-1].addr !== AW'(MAXLEN-1)) begin failures++; $display("FAIL clamp_count: got %0d writes want %0d ending at addr %0d", obs_q.size(), MAXLEN, MAXLEN-1); end
    if (done !== 1'b1 || ovf !== 1'b0) begin failures++; $display("FAIL clamp_flags: got done=%b ovf=%b want 1/0", done, ovf); end
    if (obs_q !== exp_q) begin failures++; $display("FAIL clamp_model: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      clear_logs();
      pulse_arm($urandom_range(1, 40));
      for (int c = 0; c < 150; c++) begin
        enin = ($urandom_range(0, 3) == 0);
        grp_in = rnd_group();
        arm = ($urandom_range(0, 149) == 0);
        frame_len = (AW+1)'($urandom_range(0, 70));
        clk_cycle();
      end
      arm = 1'b0; enin = 1'b0;
      idle(4);
      checks += 2;
      if (obs_q !== exp_q) begin failures++; $display("FAIL rand%0d_writes: got %0d writes want %0d", f, obs_q.size(), exp_q.size()); end
      if (done !== m_done || busy !== m_busy || ovf !== m_ovf) begin
        failures++; $display("FAIL rand%0d_flags: got d/b/o=%b%b%b want %b%b%b", f, done, busy, ovf, m_done, m_busy, m_ovf);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    pulse_arm(64);
    enin = 1'b1;
    for (int i = 0; i < 3; i++) begin grp_in = rnd_group(); clk_cycle(); end
    enin = 1'b0;
    rst_n = 1'b0;
    clk_cycle();
    rst_n = 1'b1;
    checks += 2;
    if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin failures++; $display("FAIL rstmid_ram: got we=%b addr=%0d data=%h want 0/0/0", ram_we, ram_addr, ram_wdata); end
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL rstmid_flags: got b/d/o=%b%b%b want 000", busy, done, ovf); end
    clear_logs();
    idle(12);
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL rstmid_writes: got %0d writes want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_frame8();
    test_frame6();
    test_overflow();
    test_zero_len_and_arm_enin();
    test_done_ignore();
    test_clamp();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
